ram16sdp_fifo_ctrl: RTL and testbench

- Synchronous 16-deep FIFO controller that sits directly upstream of a 16x2 simple-dual-port distributed RAM primitive and drives that RAM's write and read ports.
- Owns the write/read pointers, the occupancy count and the status flags.
- Passes write data through to the RAM and returns the RAM's asynchronous read data as first-word-fall-through (FWFT) output.
- Used wherever the design needs a small elastic buffer built from distributed RAM instead of block RAM.

---
 rtl/ram16sdp_fifo_ctrl.sv | 110 +++++++++++
 tb/tb_ram16sdp_fifo_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ram16sdp_fifo_ctrl.sv
// 16-deep FWFT FIFO controller driving a 16xDW simple-dual-port distributed RAM.
// Optional sticky OVF/UDF error flags are enabled by defining RAM16SDP_FIFO_ERR_FLAGS_EN.
module ram16sdp_fifo_ctrl #(
  parameter int DW         = 2,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          WR_EN,
  input  logic [DW-1:0] DIN,
  input  logic          RD_EN,
  output logic [DW-1:0] DOUT,
  output logic          FULL,
  output logic          EMPTY,
  output logic          AFULL,
  output logic          AEMPTY,
  output logic [4:0]    LEVEL,
  input  logic          ERR_CLR,
  output logic          OVF,
  output logic          UDF,
  output logic          RAM_WRE,
  output logic [3:0]    RAM_WAD,
  output logic [DW-1:0] RAM_DI,
  output logic [3:0]    RAM_RAD,
  input  logic [DW-1:0] RAM_DO
);

  localparam logic [4:0] AFULL_L  = 5'(AFULL_LVL);
  localparam logic [4:0] AEMPTY_L = 5'(AEMPTY_LVL);
  localparam logic [4:0] DEPTH    = 5'd16;

  logic [3:0] wp, rp;
  logic [4:0] level_q, level_nxt;
  logic       full_q, empty_q, afull_q, aempty_q;
  logic       wr_ok, rd_ok;

  // Acceptance looks only at registered flags, so a pop never makes room for a same-cycle push.
  assign wr_ok = WR_EN & ~full_q & RESETN;
  assign rd_ok = RD_EN & ~empty_q & RESETN;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_nxt = level_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_nxt = level_q + 5'd1;
      2'b01:   level_nxt = level_q - 5'd1;
      default: level_nxt = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wp       <= 4'd0;
      rp       <= 4'd0;
      level_q  <= 5'd0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 4'd1;
      if (rd_ok) rp <= rp + 4'd1;
      level_q  <= level_nxt;
      // Flags decode the next level so they move on the same edge as LEVEL.
      empty_q  <= (level_nxt == 5'd0);
      full_q   <= (level_nxt == DEPTH);
      afull_q  <= (level_nxt >= AFULL_L);
      aempty_q <= (level_nxt <= AEMPTY_L);
    end
  end

  // NOTE: the RAM array is deliberately never cleared; resetting the pointers discards its contents logically.
  assign RAM_WRE = wr_ok;
  assign RAM_WAD = wp;
  assign RAM_DI  = DIN;
  assign RAM_RAD = rp;
  assign DOUT    = RAM_DO;

  assign LEVEL  = level_q;
  assign FULL   = full_q;
  assign EMPTY  = empty_q;
  assign AFULL  = afull_q;
  assign AEMPTY = aempty_q;

`ifdef RAM16SDP_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // A new error in the clear cycle wins over ERR_CLR.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (WR_EN & full_q)  | (ovf_q & ~ERR_CLR);
      udf_q <= (RD_EN & empty_q) | (udf_q & ~ERR_CLR);
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign OVF = 1'b0;
  assign UDF = 1'b0;
`endif

endmodule

// File: tb/tb_ram16sdp_fifo_ctrl.sv
// Directed bench for ram16sdp_fifo_ctrl: behavioural 16xDW RAM plus a queue scoreboard
// holding the words expected at DOUT; flags are predicted from the queue depth.
module tb_ram16sdp_fifo_ctrl;

  localparam int DW         = 2;
  localparam int AFULL_LVL  = 12;
  localparam int AEMPTY_LVL = 2;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          WR_EN, RD_EN, ERR_CLR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          FULL, EMPTY, AFULL, AEMPTY, OVF, UDF;
  logic [4:0]    LEVEL;
  logic          RAM_WRE;
  logic [3:0]    RAM_WAD, RAM_RAD;
  logic [DW-1:0] RAM_DI, RAM_DO;

  ram16sdp_fifo_ctrl #(.DW(DW), .AFULL_LVL(AFULL_LVL), .AEMPTY_LVL(AEMPTY_LVL)) dut (
    .CLK(CLK), .RESETN(RESETN), .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN), .DOUT(DOUT),
    .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY), .LEVEL(LEVEL),
    .ERR_CLR(ERR_CLR), .OVF(OVF), .UDF(UDF), .RAM_WRE(RAM_WRE), .RAM_WAD(RAM_WAD),
    .RAM_DI(RAM_DI), .RAM_RAD(RAM_RAD), .RAM_DO(RAM_DO)
  );

  always #5 CLK = ~CLK;

  // Distributed RAM: synchronous write, asynchronous read.
  logic [DW-1:0] mem [16];
  always @(posedge CLK) if (RAM_WRE) mem[RAM_WAD] <= RAM_DI;
  assign RAM_DO = mem[RAM_RAD];

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] q[$];
  logic [3:0]    mwp = 4'd0, mrp = 4'd0;
  logic          m_ovf = 1'b0, m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = q.size();
    check({tag, ".level"},  LEVEL,  n);
    check({tag, ".empty"},  EMPTY,  n == 0);
    check({tag, ".full"},   FULL,   n == 16);
    check({tag, ".afull"},  AFULL,  n >= AFULL_LVL);
    check({tag, ".aempty"}, AEMPTY, n <= AEMPTY_LVL);
    check({tag, ".ovf"},    OVF,    m_ovf);
    check({tag, ".udf"},    UDF,    m_udf);
    check({tag, ".wad"},    RAM_WAD, mwp);
    check({tag, ".rad"},    RAM_RAD, mrp);
  endtask

  // One clock of stimulus; DOUT is scored against the queue head whenever a pop is accepted.
  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d,
                       input logic clr, input string tag);
    int   n;
    logic wok, rok;
    n   = q.size();
    wok = wr && (n < 16);
    rok = rd && (n > 0);
    WR_EN = wr; RD_EN = rd; DIN = d; ERR_CLR = clr;
    #1;
    check({tag, ".wre"}, RAM_WRE, wok);
    if (rok) check({tag, ".dout"}, DOUT, q[0]);
    @(posedge CLK); #1;
`ifdef RAM16SDP_FIFO_ERR_FLAGS_EN
    m_ovf = (wr && n == 16) | (m_ovf & ~clr);
    m_udf = (rd && n == 0)  | (m_udf & ~clr);
`endif
    if (rok) begin void'(q.pop_front()); mrp++; end
    if (wok) begin q.push_back(d); mwp++; end
    WR_EN = 1'b0; RD_EN = 1'b0; ERR_CLR = 1'b0;
    check_status(tag);
  endtask

  initial begin
    RESETN = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; ERR_CLR = 1'b0; DIN = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESETN = 1'b1;
    check_status("reset");

    // Four pushes then four pops: order and LEVEL 1..4..0.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0, "push4");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0, 1'b0, "pop4");

    // Fill to 16, then a rejected 17th push.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(i + 1), 1'b0, "fill");
    cycle(1'b1, 1'b0, 2'd3, 1'b0, "push17");

    // Full with both requests: pop wins, push rejected.
    cycle(1'b1, 1'b1, 2'd1, 1'b0, "full_both");
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, '0, 1'b0, "drain");

    // Empty with both requests: push wins, pop ignored.
    cycle(1'b1, 1'b1, 2'd2, 1'b0, "empty_both");
    check("empty_both.head", DOUT, 2);

    // Streaming at LEVEL=5 across pointer wrap.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'(i + 3), 1'b0, "to5");
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, DW'(i), 1'b0, "stream");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0, 1'b0, "drain5");

    // Underflow, clear, then underflow together with clear.
    cycle(1'b0, 1'b1, '0, 1'b0, "udf");
    cycle(1'b0, 1'b0, '0, 1'b1, "errclr");
    cycle(1'b0, 1'b1, '0, 1'b1, "udf_clr");

    // Reset mid-operation with a concurrent write request.
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0, "to9");
    RESETN = 1'b0; WR_EN = 1'b1; DIN = 2'd3;
    #1;
    check("rst.wre", RAM_WRE, 1'b0);
    @(posedge CLK); #1;
    RESETN = 1'b1; WR_EN = 1'b0;
    q.delete(); mwp = 4'd0; mrp = 4'd0; m_ovf = 1'b0; m_udf = 1'b0;
    check_status("after_rst");

    // FIFO works normally after the reset.
    cycle(1'b1, 1'b0, 2'd1, 1'b0, "post_push");
    cycle(1'b0, 1'b1, '0, 1'b0, "post_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
